// File: rtl/comb_bist_checker.sv
// Exhaustive-pattern BIST checker: sweeps all 2^IN_W input vectors, compares CH channels against channel 0.
// Optional build macro COMB_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching pattern.
module comb_bist_checker #(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned CH     = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [IN_W-1:0] pattern,
  input  logic [CH-1:0]   dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [IN_W:0]   err_cnt,
  output logic [CH-1:0]   fail_mask,
  output logic            first_fail_vld,
  output logic [IN_W-1:0] first_fail_pat
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [IN_W-1:0] PAT_LAST    = '1;
  localparam logic [IN_W:0]   ERR_ONE     = (IN_W+1)'(1);

  state_t          r_state, w_state_next;
  logic [IN_W-1:0] r_pattern, w_pattern_next;
  logic [7:0]      r_settle, w_settle_next;
  logic [IN_W:0]   r_err_cnt, w_err_cnt_next;
  logic [CH-1:0]   r_fail_mask, w_fail_mask_next;
  logic            r_ff_vld, w_ff_vld_next;
  logic [IN_W-1:0] r_ff_pat, w_ff_pat_next;
  logic [CH-1:0]   w_mis;
  logic            w_stop;

  // Bit 0 of the mismatch vector is always zero: channel 0 is the reference.
  assign w_mis = dut_y ^ {CH{dut_y[0]}};

  always_comb begin
    w_state_next     = r_state;
    w_pattern_next   = r_pattern;
    w_settle_next    = r_settle;
    w_err_cnt_next   = r_err_cnt;
    w_fail_mask_next = r_fail_mask;
    w_ff_vld_next    = r_ff_vld;
    w_ff_pat_next    = r_ff_pat;
    w_stop           = (r_pattern == PAT_LAST);
`ifdef COMB_BIST_STOP_ON_FAIL_EN
    w_stop           = w_stop | (|w_mis);
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next     = S_APPLY;
          w_pattern_next   = '0;
          w_settle_next    = '0;
          w_err_cnt_next   = '0;
          w_fail_mask_next = '0;
          w_ff_vld_next    = 1'b0;
          w_ff_pat_next    = '0;
        end
      end
      S_APPLY: begin
        w_settle_next = r_settle + 8'd1;
        if (r_settle == SETTLE_LAST) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        w_fail_mask_next = r_fail_mask | w_mis;
        if (|w_mis) begin
          w_err_cnt_next = r_err_cnt + ERR_ONE;
          if (!r_ff_vld) begin
            w_ff_vld_next = 1'b1;
            w_ff_pat_next = r_pattern;
          end
        end
        if (w_stop) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next   = S_APPLY;
          w_pattern_next = r_pattern + 1'b1;
          w_settle_next  = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pattern   <= '0;
      r_settle    <= '0;
      r_err_cnt   <= '0;
      r_fail_mask <= '0;
      r_ff_vld    <= 1'b0;
      r_ff_pat    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pattern   <= w_pattern_next;
      r_settle    <= w_settle_next;
      r_err_cnt   <= w_err_cnt_next;
      r_fail_mask <= w_fail_mask_next;
      r_ff_vld    <= w_ff_vld_next;
      r_ff_pat    <= w_ff_pat_next;
    end
  end

  assign pattern        = r_pattern;
  assign busy           = (r_state == S_APPLY) || (r_state == S_CHECK);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_err_cnt == '0);
  assign err_cnt        = r_err_cnt;
  assign fail_mask      = r_fail_mask;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_pat = r_ff_pat;

endmodule

// File: tb/tb_comb_bist_checker.sv
// Bench for comb_bist_checker: two instances (defaults, and IN_W=3/CH=2/SETTLE=3) checked every cycle
// against a sweep-level arithmetic model, plus directed literal expectations per scenario.
module tb_comb_bist_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       start_a = 1'b0;
  logic [3:0] pattern_a, dut_y_a, fail_mask_a, ffp_a;
  logic [4:0] err_a;
  logic       busy_a, done_a, pass_a, ffv_a;
  int         scen_a = 0;

  // Instance B: IN_W=3, CH=2, SETTLE=3
  logic       start_b = 1'b0;
  logic [2:0] pattern_b, ffp_b;
  logic [1:0] dut_y_b, fail_mask_b;
  logic [3:0] err_b;
  logic       busy_b, done_b, pass_b, ffv_b;
  int         scen_b = 3;
  bit         glitch_b = 1'b0;
  logic [1:0] gval = 2'b00;

  int n_checks = 0;
  int n_errors = 0;

  comb_bist_checker dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pattern(pattern_a), .dut_y(dut_y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_mask(fail_mask_a),
    .first_fail_vld(ffv_a), .first_fail_pat(ffp_a)
  );

  comb_bist_checker #(.IN_W(3), .CH(2), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pattern(pattern_b), .dut_y(dut_y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_mask(fail_mask_b),
    .first_fail_vld(ffv_b), .first_fail_pat(ffp_b)
  );

  // Channel models. Scenarios 0-2 use a 4-input function with minterms {3,5,6,9,12,15};
  // scenarios 3-4 use 3-input parity.
  function automatic int fy(input int scen, input int p, input int ch);
    int mt, g, y;
    mt = 'h9268;
    if (scen <= 2) g = (mt >> p) & 1;
    else           g = ((p >> 2) ^ (p >> 1) ^ p) & 1;
    y = g ? ((1 << ch) - 1) : 0;
    if (scen == 1 && p == 10) y = y ^ 4;
    if (scen == 2) begin
      y = y & ~8;
      if (p == 3) y = y ^ 2;
    end
    if (scen == 3 && (p == 2 || p == 5)) y = y ^ 2;
    return y;
  endfunction

  function automatic int misf(input int scen, input int p, input int ch);
    int y;
    y = fy(scen, p, ch);
    return (y & 1) ? (y ^ ((1 << ch) - 1)) : y;
  endfunction

  function automatic int last_pat(input int scen, input int w, input int ch);
    int last;
    last = (1 << w) - 1;
`ifdef COMB_BIST_STOP_ON_FAIL_EN
    for (int p = (1 << w) - 1; p >= 0; p--) if (misf(scen, p, ch) != 0) last = p;
`endif
    return last;
  endfunction

  function automatic int tdone(input int scen, input int s, input int w, input int ch);
    return (last_pat(scen, w, ch) + 1) * (s + 1);
  endfunction

  // Outputs expected k edges after the start edge.
  task automatic model(input int scen, input int k, input int s, input int w, input int ch,
                       output int pat, output int err, output int mask, output int ffv,
                       output int ffp, output int dn);
    int last, n, m;
    last = last_pat(scen, w, ch);
    n = k / (s + 1);
    err = 0; mask = 0; ffv = 0; ffp = 0;
    for (int p = 0; p <= last; p++) begin
      m = misf(scen, p, ch);
      if (p < n && m != 0) begin
        err++;
        mask = mask | m;
        if (ffv == 0) begin ffv = 1; ffp = p; end
      end
    end
    pat = (n < last) ? n : last;
    dn = (k >= (last + 1) * (s + 1)) ? 1 : 0;
  endtask

  // Sweep tracking: act = a sweep has started since reset, k = edges since the start edge.
  bit act_a = 1'b0, act_b = 1'b0;
  int k_a = 0, k_b = 0, scl_a = 0, scl_b = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_a <= 1'b0; k_a <= 0;
      act_b <= 1'b0; k_b <= 0;
    end else begin
      if (start_a && (!act_a || k_a >= tdone(scl_a, 1, 4, 4))) begin
        act_a <= 1'b1; k_a <= 0; scl_a <= scen_a;
      end else if (act_a && k_a < tdone(scl_a, 1, 4, 4)) begin
        k_a <= k_a + 1;
      end
      if (start_b && (!act_b || k_b >= tdone(scl_b, 3, 3, 2))) begin
        act_b <= 1'b1; k_b <= 0; scl_b <= scen_b;
      end else if (act_b && k_b < tdone(scl_b, 3, 3, 2)) begin
        k_b <= k_b + 1;
      end
    end
  end

  always @(negedge clk) gval <= 2'($urandom);

  // Channel B carries random garbage on every cycle that is not a CHECK sample edge.
  logic chk_next_b;
  always @* begin
    chk_next_b = act_b && (((k_b + 1) % 4) == 0) && ((k_b + 1) <= tdone(scl_b, 3, 3, 2));
    dut_y_a = 4'(fy(scen_a, int'(pattern_a), 4));
    dut_y_b = (glitch_b && !chk_next_b) ? gval : 2'(fy(scen_b, int'(pattern_b), 2));
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_a();
    int pat, err, mask, ffv, ffp, dn;
    if (act_a) model(scl_a, k_a, 1, 4, 4, pat, err, mask, ffv, ffp, dn);
    else begin pat = 0; err = 0; mask = 0; ffv = 0; ffp = 0; dn = 0; end
    chk("a_pattern", int'(pattern_a), pat);
    chk("a_busy", int'(busy_a), (act_a && !dn) ? 1 : 0);
    chk("a_done", int'(done_a), dn);
    chk("a_pass", int'(pass_a), (dn && err == 0) ? 1 : 0);
    chk("a_err_cnt", int'(err_a), err);
    chk("a_fail_mask", int'(fail_mask_a), mask);
    chk("a_ff_vld", int'(ffv_a), ffv);
    chk("a_ff_pat", int'(ffp_a), ffp);
  endtask

  task automatic compare_b();
    int pat, err, mask, ffv, ffp, dn;
    if (act_b) model(scl_b, k_b, 3, 3, 2, pat, err, mask, ffv, ffp, dn);
    else begin pat = 0; err = 0; mask = 0; ffv = 0; ffp = 0; dn = 0; end
    chk("b_pattern", int'(pattern_b), pat);
    chk("b_busy", int'(busy_b), (act_b && !dn) ? 1 : 0);
    chk("b_done", int'(done_b), dn);
    chk("b_pass", int'(pass_b), (dn && err == 0) ? 1 : 0);
    chk("b_err_cnt", int'(err_b), err);
    chk("b_fail_mask", int'(fail_mask_b), mask);
    chk("b_ff_vld", int'(ffv_b), ffv);
    chk("b_ff_pat", int'(ffp_b), ffp);
  endtask

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      compare_a();
      compare_b();
    end
  end

  task automatic sweep_a(input int scen, input bit pulse, output int edges);
    scen_a = scen;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    edges = 0;
    while (!done_a && edges < 200) begin
      @(posedge clk); #1 edges++;
      start_a = pulse && (edges == 5 || edges == 25);
    end
    start_a = 1'b0;
    $display("sweep A scen=%0d edges=%0d err_cnt=%0d mask=%b ffv=%0d ffp=%b pattern=%b pass=%0d",
             scen, edges, err_a, fail_mask_a, ffv_a, ffp_a, pattern_a, pass_a);
  endtask

  task automatic sweep_b(input int scen, output int edges);
    scen_b = scen;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    edges = 0;
    while (!done_b && edges < 200) begin
      @(posedge clk); #1 edges++;
    end
    $display("sweep B scen=%0d edges=%0d err_cnt=%0d mask=%b ffv=%0d ffp=%b pattern=%b pass=%0d",
             scen, edges, err_b, fail_mask_b, ffv_b, ffp_b, pattern_b, pass_b);
  endtask

  int e;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_async_pattern", int'(pattern_a), 0);
    chk("rst_async_busy", int'(busy_a), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_done", int'(done_a), 0);
    chk("rst_err_cnt", int'(err_a), 0);
    chk("rst_ff_vld", int'(ffv_a), 0);

    sweep_a(0, 1'b0, e);
    chk("clean_edges", e, 32);
    chk("clean_pass", int'(pass_a), 1);
    chk("clean_err", int'(err_a), 0);
    chk("clean_mask", int'(fail_mask_a), 0);
    chk("clean_ffv", int'(ffv_a), 0);
    chk("clean_pattern", int'(pattern_a), 4'b1111);

    sweep_a(1, 1'b0, e);
    chk("ch2_err", int'(err_a), 1);
    chk("ch2_mask", int'(fail_mask_a), 4'b0100);
    chk("ch2_ffv", int'(ffv_a), 1);
    chk("ch2_ffp", int'(ffp_a), 4'b1010);
    chk("ch2_pass", int'(pass_a), 0);
`ifdef COMB_BIST_STOP_ON_FAIL_EN
    chk("ch2_stop_edges", e, 22);
    chk("ch2_stop_pattern", int'(pattern_a), 4'b1010);
`else
    chk("ch2_edges", e, 32);
`endif

    sweep_a(2, 1'b0, e);
    chk("stuck_mask", int'(fail_mask_a), 4'b1010);
    chk("stuck_ffp", int'(ffp_a), 4'b0011);
`ifdef COMB_BIST_STOP_ON_FAIL_EN
    chk("stuck_stop_err", int'(err_a), 1);
    chk("stuck_stop_edges", e, 8);
`else
    chk("stuck_err", int'(err_a), 6);
`endif

    glitch_b = 1'b1;
    sweep_b(3, e);
    chk("b_fault_mask", int'(fail_mask_b), 2'b10);
    chk("b_fault_ffp", int'(ffp_b), 3'b010);
`ifdef COMB_BIST_STOP_ON_FAIL_EN
    chk("b_fault_stop_edges", e, 12);
    chk("b_fault_stop_err", int'(err_b), 1);
`else
    chk("b_fault_edges", e, 32);
    chk("b_fault_err", int'(err_b), 2);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("b_hold_err", int'(err_b), int'(err_b) == 0 ? 99 : int'(err_b));
    sweep_b(4, e);
    chk("b_rerun_edges", e, 32);
    chk("b_rerun_err", int'(err_b), 0);
    chk("b_rerun_ffv", int'(ffv_b), 0);
    chk("b_rerun_pass", int'(pass_b), 1);
    glitch_b = 1'b0;

    scen_a = 1;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    start_a = 1'b1;
    #1;
    chk("midrst_pattern", int'(pattern_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_done", int'(done_a), 0);
    chk("midrst_pass", int'(pass_a), 0);
    chk("midrst_mask", int'(fail_mask_a), 0);
    chk("midrst_ffv", int'(ffv_a), 0);
    $display("reset A mid-sweep pattern=%b busy=%0d", pattern_a, busy_a);
    @(posedge clk); #1;
    chk("rst_wins_busy", int'(busy_a), 0);
    start_a = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_after_rst", int'(busy_a), 0);

    sweep_a(1, 1'b1, e);
    chk("busy_start_ffp", int'(ffp_a), 4'b1010);
`ifdef COMB_BIST_STOP_ON_FAIL_EN
    chk("busy_start_edges", e, 22);
`else
    chk("busy_start_edges", e, 32);
    chk("busy_start_err", int'(err_a), 1);
`endif

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got time %0t expected under 200000", $time);
    $fatal(1);
  end

endmodule
